// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR coefficient loader: FSM encodings and default geometry.
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_DRAIN     = 2'd2,
    ST_WAIT_SWAP = 2'd3
  } fir_ctrl_state_e;

  localparam int N_TAPS_DEFAULT       = 17;
  localparam int COEF_WIDTH_DEFAULT   = 16;
  localparam int COEF_DECIMAL_DEFAULT = 15;

  function automatic int tap_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register files: indexed writes into shadow, all-tap copy into active.
module fir_coef_bank
  import fir_ctrl_pkg::*;
#(
  parameter int n_taps                    = N_TAPS_DEFAULT,
  parameter int coefficient_width         = COEF_WIDTH_DEFAULT,
  parameter int coefficient_decimal_width = COEF_DECIMAL_DEFAULT,
  parameter int IDX_W                     = tap_idx_width(n_taps)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en_i,
  input  logic [IDX_W-1:0]                    wr_idx_i,
  input  logic [coefficient_width-1:0]        wr_data_i,
  input  logic                                swap_i,
  output logic [n_taps*coefficient_width-1:0] coef_active_o
);

  // Unity gain in Q-format; saturate when 1.0 is not representable as a signed value.
  localparam logic [coefficient_width-1:0] IDENT_B0 =
    (coefficient_decimal_width >= coefficient_width - 1) ?
      {1'b0, {(coefficient_width-1){1'b1}}} :
      (coefficient_width'(1) << coefficient_decimal_width);

  logic [coefficient_width-1:0] shadow_q [n_taps];
  logic [coefficient_width-1:0] active_q [n_taps];

  generate
    for (genvar gi = 0; gi < n_taps; gi++) begin : g_tap
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shadow_q[gi] <= '0;
        end else if (wr_en_i && (wr_idx_i == IDX_W'(gi))) begin
          shadow_q[gi] <= wr_data_i;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          active_q[gi] <= (gi == 0) ? IDENT_B0 : '0;
        end else if (swap_i) begin
          active_q[gi] <= shadow_q[gi];
        end
      end

      assign coef_active_o[gi*coefficient_width +: coefficient_width] = active_q[gi];
    end
  endgenerate

endmodule

// File: rtl/axis_fir_coef_loader.sv
// AXI-Stream coefficient loader: collects a full tap set into a shadow bank and swaps it
// into the active bank only while the FIR is idle between samples.
module axis_fir_coef_loader
  import fir_ctrl_pkg::*;
#(
  parameter int coefficient_width         = COEF_WIDTH_DEFAULT,
  parameter int coefficient_decimal_width = COEF_DECIMAL_DEFAULT,
  parameter int n_taps                    = N_TAPS_DEFAULT
) (
  input  logic                                aclk,
  input  logic                                resetn,
  input  logic [coefficient_width-1:0]        s_axis_coef_tdata,
  input  logic                                s_axis_coef_tvalid,
  input  logic                                s_axis_coef_tlast,
  output logic                                s_axis_coef_tready,
  input  logic                                swap_enable,
  input  logic                                fir_sample_tvalid,
  input  logic                                fir_busy,
  output logic [n_taps*coefficient_width-1:0] coef_active,
  output logic                                coef_update,
  output logic                                load_error,
  output logic                                swap_pending,
  output logic [15:0]                         update_count
);

  localparam int IDX_W = tap_idx_width(n_taps);

  fir_ctrl_state_e  state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             tready_q;
  logic             coef_update_q;
  logic             load_error_q;
  logic             swap_pending_q;
  logic [15:0]      update_count_q;

  logic             beat;
  logic             last_idx;
  logic             swap_fire;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;

  assign beat      = s_axis_coef_tvalid && tready_q;
  assign last_idx  = (cnt_q == IDX_W'(n_taps - 1));
  // A sample entering this cycle still needs the old taps, so it blocks the swap too.
  assign swap_fire = (state_q == ST_WAIT_SWAP) && swap_enable && !fir_busy && !fir_sample_tvalid;
  assign wr_en     = beat && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
  assign wr_idx    = (state_q == ST_IDLE) ? '0 : cnt_q;

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tready_q       <= 1'b0;
      coef_update_q  <= 1'b0;
      load_error_q   <= 1'b0;
      swap_pending_q <= 1'b0;
      update_count_q <= '0;
    end else begin
      coef_update_q <= 1'b0;
      load_error_q  <= 1'b0;
      tready_q      <= (state_q != ST_WAIT_SWAP);
      case (state_q)
        ST_IDLE: begin
          if (beat) begin
            cnt_q <= IDX_W'(1);
            if (n_taps == 1) begin
              if (s_axis_coef_tlast) begin
                state_q        <= ST_WAIT_SWAP;
                swap_pending_q <= 1'b1;
                tready_q       <= 1'b0;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else if (s_axis_coef_tlast) begin
              load_error_q <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            if (last_idx) begin
              if (s_axis_coef_tlast) begin
                state_q        <= ST_WAIT_SWAP;
                swap_pending_q <= 1'b1;
                tready_q       <= 1'b0;
              end else begin
                state_q <= ST_DRAIN;
              end
            end else if (s_axis_coef_tlast) begin
              load_error_q <= 1'b1;
              state_q      <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (beat && s_axis_coef_tlast) begin
            load_error_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        ST_WAIT_SWAP: begin
          if (swap_fire) begin
            coef_update_q  <= 1'b1;
            update_count_q <= update_count_q + 16'd1;
            swap_pending_q <= 1'b0;
            tready_q       <= 1'b1;
            state_q        <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fir_coef_bank #(
    .n_taps                    (n_taps),
    .coefficient_width         (coefficient_width),
    .coefficient_decimal_width (coefficient_decimal_width),
    .IDX_W                     (IDX_W)
  ) u_bank (
    .clk           (aclk),
    .rst_n         (resetn),
    .wr_en_i       (wr_en),
    .wr_idx_i      (wr_idx),
    .wr_data_i     (s_axis_coef_tdata),
    .swap_i        (swap_fire),
    .coef_active_o (coef_active)
  );

  assign s_axis_coef_tready = tready_q;
  assign coef_update        = coef_update_q;
  assign load_error         = load_error_q;
  assign swap_pending       = swap_pending_q;
  assign update_count       = update_count_q;

endmodule

// File: tb/tb_axis_fir_coef_loader.sv
// Scoreboard bench: frame-level reference model predicts swaps/errors, a negedge monitor checks them.
module tb_axis_fir_coef_loader;

  localparam int NT = 17;
  localparam int W  = 16;
  localparam logic [NT*W-1:0] IDENT = {{((NT-1)*W){1'b0}}, 16'h7FFF};

  logic            aclk = 1'b0;
  logic            resetn = 1'b0;
  logic [W-1:0]    tdata = '0;
  logic            tvalid = 1'b0;
  logic            tlast = 1'b0;
  logic            tready;
  logic            swap_enable = 1'b0;
  logic            fir_sample_tvalid = 1'b0;
  logic            fir_busy = 1'b0;
  logic [NT*W-1:0] coef_active;
  logic            coef_update;
  logic            load_error;
  logic            swap_pending;
  logic [15:0]     update_count;

  always #5 aclk = ~aclk;

  axis_fir_coef_loader dut (
    .aclk               (aclk),
    .resetn             (resetn),
    .s_axis_coef_tdata  (tdata),
    .s_axis_coef_tvalid (tvalid),
    .s_axis_coef_tlast  (tlast),
    .s_axis_coef_tready (tready),
    .swap_enable        (swap_enable),
    .fir_sample_tvalid  (fir_sample_tvalid),
    .fir_busy           (fir_busy),
    .coef_active        (coef_active),
    .coef_update        (coef_update),
    .load_error         (load_error),
    .swap_pending       (swap_pending),
    .update_count       (update_count)
  );

  typedef struct {
    logic [NT*W-1:0] vec;
    logic [15:0]     cnt;
  } swap_exp_t;

  swap_exp_t    swap_q[$];
  int           err_q[$];
  logic [W-1:0] frame[$];
  logic [15:0]  model_cnt = '0;
  int           err_id = 0;
  int           checks = 0;
  int           failures = 0;
  int           env_mode = 0;  // 0 open, 1 busy, 2 random, 3 sample-in-flight only

  task automatic chk(input string nm, input logic [NT*W-1:0] act, input logic [NT*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Reference model: a set is valid iff it is exactly NT beats long.
  task automatic model_beat(input logic [W-1:0] d, input logic last);
    swap_exp_t e;
    frame.push_back(d);
    if (last) begin
      if (frame.size() == NT) begin
        e.vec = '0;
        for (int i = 0; i < NT; i++) e.vec[i*W +: W] = frame[i];
        model_cnt = model_cnt + 16'd1;
        e.cnt = model_cnt;
        swap_q.push_back(e);
        $display("tx: set of %0d beats -> expect swap #%0d", frame.size(), model_cnt);
      end else begin
        err_id++;
        err_q.push_back(err_id);
        $display("tx: set of %0d beats -> expect load_error", frame.size());
      end
      frame.delete();
    end
  endtask

  task automatic send_frame(input int len, input int stop_at, input bit incr,
                            input logic [W-1:0] base, input int gap_pct);
    for (int i = 0; i < len && i < stop_at; i++) begin
      logic [W-1:0] d;
      logic acc;
      int waited;
      d = incr ? base + W'(i) : W'($urandom);
      while ($urandom_range(99) < gap_pct) begin
        tvalid = 1'b0;
        @(posedge aclk); #1;
      end
      tvalid = 1'b1; tdata = d; tlast = (i == len - 1);
      acc = 1'b0; waited = 0;
      while (!acc) begin
        @(negedge aclk); acc = tready;
        @(posedge aclk); #1;
        if (!acc) begin
          waited++;
          if (waited > 300) begin
            checks++; failures++;
            $display("FAIL tready_timeout actual=0 required=1");
            tvalid = 1'b0; tlast = 1'b0;
            return;
          end
        end
      end
      model_beat(d, (i == len - 1));
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  // Environment: swap gate inputs.
  initial begin
    forever begin
      @(posedge aclk); #1;
      case (env_mode)
        0: begin swap_enable = 1'b1; fir_busy = 1'b0; fir_sample_tvalid = 1'b0; end
        1: begin swap_enable = 1'b1; fir_busy = 1'b1; fir_sample_tvalid = 1'b0; end
        2: begin
          swap_enable       = ($urandom_range(3) != 0);
          fir_busy          = ($urandom_range(2) == 0);
          fir_sample_tvalid = ($urandom_range(3) == 0);
        end
        default: begin swap_enable = 1'b1; fir_busy = 1'b0; fir_sample_tvalid = 1'b1; end
      endcase
    end
  end

  // Monitor.
  logic [NT*W-1:0] prev_act = IDENT;
  logic prev_pend = 1'b0, prev_gate = 1'b0, prev_live = 1'b0, rst_checked = 1'b0;
  initial begin
    forever begin
      @(negedge aclk);
      if (!resetn) begin
        if (!rst_checked) begin
          chk("rst_active", coef_active, IDENT);
          chk("rst_tready", {271'd0, tready}, '0);
          chk("rst_update_count", {256'd0, update_count}, '0);
          chk("rst_flags", {269'd0, coef_update, load_error, swap_pending}, '0);
          rst_checked = 1'b1;
        end
        prev_act = IDENT; prev_pend = 1'b0; prev_gate = 1'b0; prev_live = 1'b0;
      end else begin
        rst_checked = 1'b0;
        if (prev_live && prev_pend && prev_gate)
          chk("swap_when_gate_open", {271'd0, coef_update}, 1);
        if (coef_update) begin
          chk("swap_gate_was_open", {270'd0, prev_pend, prev_gate}, 3);
          if (swap_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_swap actual=%h required=none", coef_active);
          end else begin
            swap_exp_t e;
            e = swap_q.pop_front();
            chk("swap_taps", coef_active, e.vec);
            chk("swap_count", {256'd0, update_count}, {256'd0, e.cnt});
            $display("rx: swap count=%0d b0=%h b16=%h", update_count,
                     coef_active[15:0], coef_active[NT*W-1 -: W]);
          end
        end else if (prev_live) begin
          chk("active_stable", coef_active, prev_act);
        end
        if (load_error) begin
          checks++;
          if (err_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_load_error actual=1 required=0");
          end else begin
            void'(err_q.pop_front());
            $display("rx: load_error");
          end
        end
        if (swap_pending) chk("tready_low_while_pending", {271'd0, tready}, '0);
        prev_act  = coef_active;
        prev_pend = swap_pending;
        prev_gate = swap_enable && !fir_busy && !fir_sample_tvalid;
        prev_live = 1'b1;
      end
    end
  end

  initial begin
    int waited;
    repeat (3) @(posedge aclk);
    #1 resetn = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("init_active", coef_active, IDENT);
    chk("init_tready", {271'd0, tready}, 1);
    chk("init_update_count", {256'd0, update_count}, '0);
    @(posedge aclk); #1;

    // Normal load.
    env_mode = 0;
    send_frame(17, 99, 1'b1, 16'h0100, 0);
    repeat (4) @(posedge aclk); #1;

    // Busy blocking, then a sample-in-flight cycle, then release.
    env_mode = 1;
    repeat (2) @(posedge aclk); #1;
    send_frame(17, 99, 1'b1, 16'h0200, 0);
    repeat (20) begin
      @(negedge aclk);
      chk("busy_pending", {271'd0, swap_pending}, 1);
      chk("busy_tready", {271'd0, tready}, '0);
    end
    env_mode = 3;
    repeat (3) @(posedge aclk); #1;
    env_mode = 0;
    repeat (4) @(posedge aclk); #1;

    // Short set then a good set.
    send_frame(5, 99, 1'b1, 16'h0300, 0);
    send_frame(17, 99, 1'b1, 16'h0400, 0);
    repeat (4) @(posedge aclk); #1;

    // Long set.
    send_frame(20, 99, 1'b1, 16'h0500, 0);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("long_no_pending", {271'd0, swap_pending}, '0);
    @(posedge aclk); #1;

    // Reset mid-load.
    send_frame(17, 9, 1'b1, 16'h0600, 0);
    resetn = 1'b0;
    frame.delete();
    model_cnt = '0;
    repeat (3) @(posedge aclk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge aclk); #1;
    send_frame(17, 99, 1'b1, 16'h0700, 0);
    repeat (4) @(posedge aclk); #1;

    // Randomized sets with random gate activity.
    env_mode = 2;
    for (int f = 0; f < 30; f++) begin
      int len;
      len = ($urandom_range(3) != 0) ? NT : int'($urandom_range(25, 1));
      send_frame(len, 99, 1'b0, '0, 20);
    end
    env_mode = 0;
    waited = 0;
    while (swap_q.size() != 0 && waited < 500) begin
      @(posedge aclk); waited++;
    end
    repeat (4) @(posedge aclk);
    @(negedge aclk);
    chk("drain_swaps_left", 272'(swap_q.size()), '0);
    chk("drain_errors_left", 272'(err_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
